// File: rtl/intr_ctrl_pkg.sv
// Shared trap-controller definitions: CSR addresses, mcause codes, mstatus
// bit positions, FSM state encoding and mstatus update helpers.
package core_defines;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SOFT   = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DRAIN      = 3'd1;
  localparam logic [2:0] WR_MEPC    = 3'd2;
  localparam logic [2:0] WR_MCAUSE  = 3'd3;
  localparam logic [2:0] WR_MSTATUS = 3'd4;
  localparam logic [2:0] JUMP       = 3'd5;

  // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// CSR write port and IF redirect driven by the trap controller.
interface intr_ctrl_if;
  logic        cl_csr_we;
  logic [11:0] cl_csr_waddr;
  logic [31:0] cl_csr_wdata;
  logic        cl_jump_flag;
  logic [31:0] cl_jump_pc;

  modport master (
    output cl_csr_we, cl_csr_waddr, cl_csr_wdata, cl_jump_flag, cl_jump_pc
  );

  modport slave (
    input cl_csr_we, cl_csr_waddr, cl_csr_wdata, cl_jump_flag, cl_jump_pc
  );
endinterface

// File: rtl/intr_ctrl_prio.sv
// Combinational trap priority/enable encoder: mret > ecall > ebreak >
// external > software > timer.
module intr_prio
  import core_defines::*;
(
  input  logic        mret,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic [2:0]  irq_pend,   // {ext, soft, timer}
  input  logic [2:0]  irq_mask,   // matching mie bits
  input  logic        global_ie,
  input  logic        redirect,
  output logic        accept,
  output logic        is_mret,
  output logic [31:0] cause,
  output logic        use_id_pc
);

  logic [2:0] irq_en;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_irq_en
      assign irq_en[gi] = irq_pend[gi] & irq_mask[gi] & global_ie & ~redirect;
    end
  endgenerate

  always_comb begin
    accept    = 1'b1;
    is_mret   = 1'b0;
    use_id_pc = 1'b0;
    cause     = '0;
    if (mret) begin
      is_mret = 1'b1;
    end else if (ecall) begin
      use_id_pc = 1'b1;
      cause     = CAUSE_ECALL;
    end else if (ebreak) begin
      use_id_pc = 1'b1;
      cause     = CAUSE_EBREAK;
    end else if (irq_en[2]) begin
      cause = CAUSE_EXT;
    end else if (irq_en[1]) begin
      cause = CAUSE_SOFT;
    end else if (irq_en[0]) begin
      cause = CAUSE_TIMER;
    end else begin
      accept = 1'b0;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode trap controller: accepts a trap or mret, drains the pipe,
// writes mepc/mcause/mstatus and redirects IF.
module intr_ctrl
  import core_defines::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_timer_i,
  input  logic        irq_soft_i,
  input  logic        irq_ext_i,
  input  logic        id_ecall_i,
  input  logic        id_ebreak_i,
  input  logic        id_mret_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] if_pc_i,
  input  logic        id_jump_flag_i,
  input  logic        ex_branch_flag_i,
  input  logic        inst_forward_over_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mie_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  output logic        cl_stall_o,
  output logic        cl_busy_o,
  intr_ctrl_if.master cl_if
);

  logic [2:0]  state_reg, state_next;
  logic        kind_reg;            // 1 = mret, 0 = trap
  logic [31:0] cause_reg, epc_reg;
  logic        prio_accept, prio_is_mret, prio_use_id_pc;
  logic [31:0] prio_cause;
  logic        accept_now;
  logic [31:0] trap_base, jump_target;
  logic        unused_csr_bits;

  assign unused_csr_bits = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:4],
                             csr_mie_i[2:0], csr_mepc_i[1:0]};

  intr_prio u_prio (
    .mret      (id_mret_i),
    .ecall     (id_ecall_i),
    .ebreak    (id_ebreak_i),
    .irq_pend  ({irq_ext_i, irq_soft_i, irq_timer_i}),
    .irq_mask  ({csr_mie_i[11], csr_mie_i[3], csr_mie_i[7]}),
    .global_ie (csr_mstatus_i[MSTATUS_MIE]),
    .redirect  (id_jump_flag_i | ex_branch_flag_i),
    .accept    (prio_accept),
    .is_mret   (prio_is_mret),
    .cause     (prio_cause),
    .use_id_pc (prio_use_id_pc)
  );

  // Gate with rst_n so nothing is seen on the outputs while reset is held.
  assign accept_now = rst_n && (state_reg == IDLE) && prio_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      kind_reg  <= 1'b0;
      cause_reg <= '0;
      epc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept_now) begin
        kind_reg  <= prio_is_mret;
        cause_reg <= prio_cause;
        epc_reg   <= prio_use_id_pc ? id_pc_i : if_pc_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (accept_now) state_next = DRAIN;
      DRAIN:      if (inst_forward_over_i) state_next = kind_reg ? WR_MSTATUS : WR_MEPC;
      WR_MEPC:    state_next = WR_MCAUSE;
      WR_MCAUSE:  state_next = WR_MSTATUS;
      WR_MSTATUS: state_next = JUMP;
      JUMP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  assign trap_base = {csr_mtvec_i[31:2], 2'b00};

  always_comb begin
    if (kind_reg)
      jump_target = {csr_mepc_i[31:2], 2'b00};
    else if (csr_mtvec_i[1:0] == 2'b01 && cause_reg[31])
      jump_target = trap_base + {26'd0, cause_reg[3:0], 2'b00};
    else
      jump_target = trap_base;
  end

  always_comb begin
    cl_stall_o         = 1'b0;
    cl_busy_o          = (state_reg != IDLE);
    cl_if.cl_csr_we    = 1'b0;
    cl_if.cl_csr_waddr = '0;
    cl_if.cl_csr_wdata = '0;
    cl_if.cl_jump_flag = 1'b0;
    cl_if.cl_jump_pc   = '0;
    case (state_reg)
      IDLE:  cl_stall_o = accept_now;
      DRAIN: cl_stall_o = 1'b1;
      WR_MEPC: begin
        cl_stall_o         = 1'b1;
        cl_if.cl_csr_we    = 1'b1;
        cl_if.cl_csr_waddr = CSR_MEPC;
        cl_if.cl_csr_wdata = epc_reg;
      end
      WR_MCAUSE: begin
        cl_stall_o         = 1'b1;
        cl_if.cl_csr_we    = 1'b1;
        cl_if.cl_csr_waddr = CSR_MCAUSE;
        cl_if.cl_csr_wdata = cause_reg;
      end
      WR_MSTATUS: begin
        cl_stall_o         = 1'b1;
        cl_if.cl_csr_we    = 1'b1;
        cl_if.cl_csr_waddr = CSR_MSTATUS;
        cl_if.cl_csr_wdata = kind_reg ? mstatus_on_mret(csr_mstatus_i)
                                      : mstatus_on_trap(csr_mstatus_i);
      end
      JUMP: begin
        cl_if.cl_jump_flag = 1'b1;
        cl_if.cl_jump_pc   = jump_target;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized bench for intr_ctrl against a transaction-level trap model.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_timer, irq_soft, irq_ext;
  logic        id_ecall, id_ebreak, id_mret;
  logic [31:0] id_pc, if_pc;
  logic        id_jump_flag, ex_branch_flag, fwd_over;
  logic [31:0] mstatus, mie, mtvec, mepc;
  logic        cl_stall, cl_busy;

  intr_ctrl_if cl_if ();

  intr_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .irq_timer_i         (irq_timer),
    .irq_soft_i          (irq_soft),
    .irq_ext_i           (irq_ext),
    .id_ecall_i          (id_ecall),
    .id_ebreak_i         (id_ebreak),
    .id_mret_i           (id_mret),
    .id_pc_i             (id_pc),
    .if_pc_i             (if_pc),
    .id_jump_flag_i      (id_jump_flag),
    .ex_branch_flag_i    (ex_branch_flag),
    .inst_forward_over_i (fwd_over),
    .csr_mstatus_i       (mstatus),
    .csr_mie_i           (mie),
    .csr_mtvec_i         (mtvec),
    .csr_mepc_i          (mepc),
    .cl_stall_o          (cl_stall),
    .cl_busy_o           (cl_busy),
    .cl_if               (cl_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    irq_timer = 0; irq_soft = 0; irq_ext = 0;
    id_ecall = 0; id_ebreak = 0; id_mret = 0;
    id_jump_flag = 0; ex_branch_flag = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".we"},   {31'd0, cl_if.cl_csr_we},    32'd0);
    check({tag, ".jump"}, {31'd0, cl_if.cl_jump_flag}, 32'd0);
    check({tag, ".busy"}, {31'd0, cl_busy},            32'd0);
  endtask

  // Drives one candidate trap event (inputs already set by caller) from the
  // accept cycle to the return to IDLE, comparing every cycle.
  task automatic run_txn(input int drain);
    bit          acc, is_mret;
    logic [31:0] cause, epc, tgt, base;
    logic [11:0] w_addr [3];
    logic [31:0] w_data [3];
    int          nw;
    bit          irq_ok;

    irq_ok  = !id_jump_flag && !ex_branch_flag && mstatus[3];
    acc     = 1; is_mret = 0; cause = 0; epc = 0;
    if (id_mret)                          is_mret = 1;
    else if (id_ecall)                    begin cause = 11; epc = id_pc; end
    else if (id_ebreak)                   begin cause = 3;  epc = id_pc; end
    else if (irq_ok && irq_ext && mie[11])  begin cause = 32'h8000000B; epc = if_pc; end
    else if (irq_ok && irq_soft && mie[3])  begin cause = 32'h80000003; epc = if_pc; end
    else if (irq_ok && irq_timer && mie[7]) begin cause = 32'h80000007; epc = if_pc; end
    else acc = 0;

    base = mtvec & 32'hFFFF_FFFC;
    if (is_mret) begin
      tgt = mepc & 32'hFFFF_FFFC;
      w_addr[0] = 12'h300;
      w_data[0] = (mstatus & ~32'h1888) | 32'h1880 | (mstatus[7] ? 32'h8 : 32'h0);
      nw = 1;
    end else begin
      tgt = (mtvec[1:0] == 2'b01 && cause[31]) ? base + cause[3:0] * 4 : base;
      w_addr[0] = 12'h341; w_data[0] = epc;
      w_addr[1] = 12'h342; w_data[1] = cause;
      w_addr[2] = 12'h300;
      w_data[2] = (mstatus & ~32'h1888) | 32'h1800 | (mstatus[3] ? 32'h80 : 32'h0);
      nw = 3;
    end

    fwd_over = 1'($urandom_range(0, 1));
    #3;
    check("accept.stall", {31'd0, cl_stall}, {31'd0, acc});
    check_quiet("accept");
    step();
    clear_events();

    if (acc) begin
      for (int i = 0; i <= drain; i++) begin
        fwd_over = (i == drain);
        #3;
        check("drain.stall", {31'd0, cl_stall}, 32'd1);
        check("drain.busy",  {31'd0, cl_busy},  32'd1);
        check("drain.we",    {31'd0, cl_if.cl_csr_we}, 32'd0);
        step();
      end
      for (int i = 0; i < nw; i++) begin
        fwd_over = 1'($urandom_range(0, 1));
        #3;
        check("wr.we",    {31'd0, cl_if.cl_csr_we}, 32'd1);
        check("wr.addr",  {20'd0, cl_if.cl_csr_waddr}, {20'd0, w_addr[i]});
        check("wr.data",  cl_if.cl_csr_wdata, w_data[i]);
        check("wr.stall", {31'd0, cl_stall}, 32'd1);
        check("wr.jump",  {31'd0, cl_if.cl_jump_flag}, 32'd0);
        step();
      end
      #3;
      check("jump.flag",  {31'd0, cl_if.cl_jump_flag}, 32'd1);
      check("jump.pc",    cl_if.cl_jump_pc, tgt);
      check("jump.stall", {31'd0, cl_stall}, 32'd0);
      check("jump.we",    {31'd0, cl_if.cl_csr_we}, 32'd0);
      step();
    end
    #3;
    check("idle.stall", {31'd0, cl_stall}, 32'd0);
    check_quiet("idle");
    step();
    $display("txn %0d accept=%0d mret=%0d cause=%h epc=%h target=%h drain=%0d",
             txn_id, acc, is_mret, cause, epc, acc ? tgt : 32'd0, drain);
    txn_id++;
  endtask

  initial begin
    rst_n = 0; clear_events(); fwd_over = 0;
    id_pc = 0; if_pc = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    step(); step();
    // Pending enabled interrupt during reset must not show.
    mstatus = 32'h8; mie = 32'h80; irq_timer = 1;
    #3;
    check("reset.stall", {31'd0, cl_stall}, 32'd0);
    check_quiet("reset");
    check("reset.pc", cl_if.cl_jump_pc, 32'd0);
    step();
    clear_events();
    rst_n = 1;
    step();

    // Timer interrupt, direct mode.
    mstatus = 32'h8; mie = 32'h80; mtvec = 32'h100; if_pc = 32'h2000;
    irq_timer = 1; run_txn(0);
    // Vectored external interrupt.
    mie = 32'h800; mtvec = 32'h101; irq_ext = 1; run_txn(0);
    // ecall with a long drain.
    mstatus = 0; id_pc = 32'h40; id_ecall = 1; run_txn(5);
    // mret.
    mstatus = 32'h1880; mepc = 32'h2004; id_mret = 1; run_txn(0);
    // ecall beats a simultaneous enabled external interrupt.
    mstatus = 32'h8; mie = 32'h800; mtvec = 32'h101; id_pc = 32'h80;
    id_ecall = 1; irq_ext = 1; run_txn(1);
    // Branch in flight blocks the interrupt until it drops.
    for (int i = 0; i < 3; i++) begin
      irq_soft = 1; mie = 32'h8; ex_branch_flag = 1; run_txn(0);
    end
    irq_soft = 1; mie = 32'h8; run_txn(0);

    // Reset in WR_MCAUSE: no further write or jump.
    mstatus = 32'h8; id_pc = 32'h300; id_ecall = 1; fwd_over = 1;
    step(); clear_events();
    step(); step();
    #3;
    check("rstmid.addr", {20'd0, cl_if.cl_csr_waddr}, 32'h342);
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check_quiet("rstmid");
      check("rstmid.stall", {31'd0, cl_stall}, 32'd0);
      step();
    end

    for (int n = 0; n < 300; n++) begin
      mstatus = $urandom; mie = $urandom; mepc = $urandom;
      mtvec = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(0, 1))};
      id_pc = $urandom; if_pc = $urandom;
      id_mret   = ($urandom_range(0, 7) == 0);
      id_ecall  = ($urandom_range(0, 5) == 0);
      id_ebreak = ($urandom_range(0, 5) == 0);
      irq_ext   = ($urandom_range(0, 2) == 0);
      irq_soft  = ($urandom_range(0, 2) == 0);
      irq_timer = ($urandom_range(0, 2) == 0);
      id_jump_flag   = ($urandom_range(0, 4) == 0);
      ex_branch_flag = ($urandom_range(0, 4) == 0);
      run_txn($urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
